// File: rtl/hold_watch.sv
// Pulse-width and overlap checker for the g/f hold-FSM level outputs.
// Reports each pulse's sampled-high length and flags short, long or overlapping pulses.
module hold_watch #(
  parameter int CNT_W    = 8,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g_in,
  input  logic             f_in,
  input  logic             clr,
  output logic [CNT_W-1:0] g_len,
  output logic             g_vld,
  output logic [CNT_W-1:0] f_len,
  output logic             f_vld,
  output logic             g_err,
  output logic             f_err,
  output logic             ovl_err
);

  // state | meaning
  // IDLE  | no pulse in progress
  // HOLD  | pulse high, length still within MAX_HOLD
  // LONG  | pulse exceeded MAX_HOLD, counter saturates
  typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

  logic [1:0] s_in;
  logic [1:0] s_prv;
  logic       ovl_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_in  <= '0;
      s_prv <= '0;
    end else begin
      s_in  <= {f_in, g_in};
      s_prv <= s_in;
    end
  end

  assign ovl_set = s_in[0] & s_in[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ovl_err <= 1'b0;
    else if (clr) ovl_err <= ovl_set;
    else          ovl_err <= ovl_err | ovl_set;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] len, len_nxt;
    logic             vld, vld_nxt;
    logic             err, err_set;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len;
      vld_nxt   = 1'b0;
      err_set   = 1'b0;
      case (state)
        IDLE: begin
          if (s_in[ch] && !s_prv[ch]) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(1);
          end
        end
        HOLD: begin
          if (s_in[ch]) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == MAX_C) begin
              state_nxt = LONG;
              err_set   = 1'b1;
            end
          end else begin
            len_nxt   = cnt;
            vld_nxt   = 1'b1;
            state_nxt = IDLE;
            if (cnt < MIN_C) err_set = 1'b1;
          end
        end
        LONG: begin
          if (s_in[ch]) begin
            if (cnt != '1) cnt_nxt = cnt + 1'b1;
          end else begin
            len_nxt   = cnt;
            vld_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // a flag raised in the same cycle as clr survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        len   <= '0;
        vld   <= 1'b0;
        err   <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        len   <= len_nxt;
        vld   <= vld_nxt;
        err   <= clr ? err_set : (err | err_set);
      end
    end
  end

  assign g_len = g_ch[0].len;
  assign g_vld = g_ch[0].vld;
  assign g_err = g_ch[0].err;
  assign f_len = g_ch[1].len;
  assign f_vld = g_ch[1].vld;
  assign f_err = g_ch[1].err;

endmodule

// File: tb/tb_hold_watch.sv
// Bench for hold_watch: run-length reference model over the driven input history.
module tb_hold_watch;
  localparam int MIN_HOLD = 2;
  localparam int MAX_HOLD = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       g_in = 1'b0, f_in = 1'b0, clr = 1'b0;
  logic [7:0] g_len, f_len;
  logic       g_vld, f_vld, g_err, f_err, ovl_err;

  logic       b_g_in = 1'b0;
  logic       b_f_in = 1'b0;
  logic       b_clr = 1'b0;
  logic [3:0] b_g_len, b_f_len;
  logic       b_g_vld, b_f_vld, b_g_err, b_f_err, b_ovl_err;

  hold_watch #(.CNT_W(8), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .g_in(g_in), .f_in(f_in), .clr(clr),
    .g_len(g_len), .g_vld(g_vld), .f_len(f_len), .f_vld(f_vld),
    .g_err(g_err), .f_err(f_err), .ovl_err(ovl_err));

  hold_watch #(.CNT_W(4), .MIN_HOLD(2), .MAX_HOLD(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .g_in(b_g_in), .f_in(b_f_in), .clr(b_clr),
    .g_len(b_g_len), .g_vld(b_g_vld), .f_len(b_f_len), .f_vld(b_f_vld),
    .g_err(b_g_err), .f_err(b_f_err), .ovl_err(b_ovl_err));

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  bit         gq[$], fq[$];
  logic [7:0] e_len[2];
  logic       e_err[2];
  logic       e_ovl;
  int         g_strobes, b_strobes;
  logic [7:0] g_lens[$];

  function automatic bit hist(input bit sel, input int i);
    if (i < 0) return 1'b0;
    return sel ? fq[i] : gq[i];
  endfunction

  // number of consecutive high samples ending at index j
  function automatic int run_end(input bit sel, input int j);
    int n = 0;
    while (j >= 0 && hist(sel, j)) begin
      n++;
      j--;
    end
    return n;
  endfunction

  task automatic clear_model();
    gq.delete();
    fq.delete();
    e_len[0] = '0; e_len[1] = '0;
    e_err[0] = 1'b0; e_err[1] = 1'b0;
    e_ovl = 1'b0;
    g_strobes = 0;
    b_strobes = 0;
    g_lens.delete();
  endtask

  // drive one cycle, then compare every output against the model
  task automatic step(input bit g, input bit f, input bit c);
    int         k, r_now, r_prev;
    bit         sel, ev, set;
    logic [7:0] o_len[2];
    logic       o_vld[2], o_err[2];
    g_in = g; f_in = f; clr = c;
    gq.push_back(g);
    fq.push_back(f);
    @(posedge clk);
    #1;
    if (b_g_vld) b_strobes++;
    if (g_vld) begin
      g_strobes++;
      g_lens.push_back(g_len);
    end
    k = gq.size() - 1;
    o_len[0] = g_len; o_len[1] = f_len;
    o_vld[0] = g_vld; o_vld[1] = f_vld;
    o_err[0] = g_err; o_err[1] = f_err;
    for (int ch = 0; ch < 2; ch++) begin
      sel    = bit'(ch);
      r_now  = run_end(sel, k - 1);
      r_prev = run_end(sel, k - 2);
      ev     = hist(sel, k - 2) && !hist(sel, k - 1);
      set    = (r_now == MAX_HOLD + 1) || (ev && r_prev < MIN_HOLD);
      if (ev) e_len[ch] = (r_prev > 255) ? 8'd255 : 8'(r_prev);
      e_err[ch] = (c ? 1'b0 : e_err[ch]) | set;
      n_tests += 3;
      if (o_vld[ch] !== ev) begin
        n_fail++;
        $display("FAIL vld ch%0d cyc%0d: got %b want %b", ch, k, o_vld[ch], ev);
      end
      if (o_len[ch] !== e_len[ch]) begin
        n_fail++;
        $display("FAIL len ch%0d cyc%0d: got %0d want %0d", ch, k, o_len[ch], e_len[ch]);
      end
      if (o_err[ch] !== e_err[ch]) begin
        n_fail++;
        $display("FAIL err ch%0d cyc%0d: got %b want %b", ch, k, o_err[ch], e_err[ch]);
      end
    end
    e_ovl = (c ? 1'b0 : e_ovl) | (hist(1'b0, k - 1) & hist(1'b1, k - 1));
    n_tests++;
    if (ovl_err !== e_ovl) begin
      n_fail++;
      $display("FAIL ovl cyc%0d: got %b want %b", k, ovl_err, e_ovl);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    g_in = 1'b0; f_in = 1'b0; clr = 1'b0; b_g_in = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({g_len, f_len, g_vld, f_vld, g_err, f_err, ovl_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {g_len, f_len, g_vld, f_vld, g_err, f_err, ovl_err});
    end
    n_tests++;
    if ({b_g_len, b_g_vld, b_g_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %h want 0", {b_g_len, b_g_vld, b_g_err});
    end
  endtask

  task automatic test_single();
    do_reset();
    repeat (5) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    n_tests++;
    if (g_strobes != 1 || g_len !== 8'd5 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_g: got strobes=%0d len=%0d err=%b want 1/5/0", g_strobes, g_len, g_err);
    end
  endtask

  task automatic test_short();
    do_reset();
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    n_tests++;
    if (f_len !== 8'd1 || f_err !== 1'b1 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_f: got len=%0d f_err=%b g_err=%b want 1/1/0", f_len, f_err, g_err);
    end
    do_reset();
    repeat (MIN_HOLD) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (f_len !== 8'(MIN_HOLD) || f_err !== 1'b0) begin
      n_fail++;
      $display("FAIL min_edge: got len=%0d err=%b want %0d/0", f_len, f_err, MIN_HOLD);
    end
  endtask

  task automatic test_long();
    do_reset();
    repeat (MAX_HOLD) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (g_len !== 8'(MAX_HOLD) || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_edge: got len=%0d err=%b want %0d/0", g_len, g_err, MAX_HOLD);
    end
    do_reset();
    repeat (30) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (g_len !== 8'd30 || g_err !== 1'b1 || g_strobes != 1) begin
      n_fail++;
      $display("FAIL long_g: got len=%0d err=%b strobes=%0d want 30/1/1", g_len, g_err, g_strobes);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (ovl_err !== 1'b1 || g_err !== 1'b0 || f_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap: got ovl=%b g_err=%b f_err=%b want 1/0/0", ovl_err, g_err, f_err);
    end
    step(0, 0, 1);
    step(0, 0, 0);
    n_tests++;
    if (ovl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_clr: got %b want 0", ovl_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    n_tests++;
    if (g_lens.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d strobes want 2", g_lens.size());
    end else if (g_lens[0] !== 8'd3 || g_lens[1] !== 8'd4) begin
      n_fail++;
      $display("FAIL b2b_lens: got %0d,%0d want 3,4", g_lens[0], g_lens[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) step(1, 0, 0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (g_vld !== 1'b0 || g_len !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got vld=%b len=%0d want 0/0", g_vld, g_len);
    end
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (g_len !== 8'd4 || g_strobes != 1) begin
      n_fail++;
      $display("FAIL reset_resume: got len=%0d strobes=%0d want 4/1", g_len, g_strobes);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    b_g_in = 1'b1;
    repeat (20) step(0, 0, 0);
    b_g_in = 1'b0;
    repeat (3) step(0, 0, 0);
    n_tests++;
    if (b_g_len !== 4'd15 || b_g_err !== 1'b1 || b_strobes != 1) begin
      n_fail++;
      $display("FAIL saturate: got len=%0d err=%b strobes=%0d want 15/1/1", b_g_len, b_g_err, b_strobes);
    end
  endtask

  task automatic test_random();
    int  rem[2];
    bit  lvl[2];
    bit  c;
    do_reset();
    rem[0] = 0; rem[1] = 0; lvl[0] = 1'b1; lvl[1] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = !lvl[ch];
          rem[ch] = lvl[ch] ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 4));
        end
        rem[ch]--;
      end
      c = ($urandom_range(0, 19) == 0);
      step(lvl[0], lvl[1], c);
    end
    repeat (3) step(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_short();
    test_long();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
